// File: rtl/pid_mult_scheduler.sv
// pid_mult_scheduler: one shared iterative shift-and-add multiplier, time-multiplexed between the
// three PID gain terms (requester 0 = P, 1 = I, 2 = D) with round-robin arbitration.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   req[2:0]     per-requester request level
//   a0..a2       per-requester multiplicand
//   b0..b2       per-requester multiplier
//   busy         high whenever the FSM is not idle
//   grant[2:0]   one-hot owner, held from the latch edge through the done cycle
//   done[2:0]    one-hot, one-cycle pulse to the owner when product is valid
//   product      saturated unsigned product, held until the next done
//   ovf          saturation flag, held with product
module pid_mult_scheduler #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b2,
  output logic             busy,
  output logic [2:0]       grant,
  output logic [2:0]       done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e               state_q;
  logic [1:0]           ptr_q;
  logic [1:0]           owner_q;
  logic [CntW-1:0]      cnt_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2:0]           grant_q;
  logic [2:0]           done_q;
  logic [WIDTH-1:0]     product_q;
  logic                 ovf_q;

  // Round-robin pick: lowest offset from the pointer wins.
  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;

  always_comb begin
    pick_valid = |req;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int k = 2; k >= 0; k--) begin
      cand = 2'((int'(ptr_q) + k) % 3);
      if (req[cand]) pick_idx = cand;
    end
  end

  always_comb begin
    pick_a = a2;
    pick_b = b2;
    unique case (pick_idx)
      2'd0: begin
        pick_a = a0;
        pick_b = b0;
      end
      2'd1: begin
        pick_a = a1;
        pick_b = b1;
      end
      default: begin
        pick_a = a2;
        pick_b = b2;
      end
    endcase
  end

  // One partial product per iteration, LSB of the multiplier first.
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    addend   = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    acc_next = acc_q + addend;
  end

  logic [1:0] ptr_next;
  assign ptr_next = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q <= StIter;
            grant_q <= 3'b001 << pick_idx;
            owner_q <= pick_idx;
            a_q     <= pick_a;
            b_q     <= pick_b;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StIter: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StDone;
            done_q  <= grant_q;
            if (|acc_next[2*WIDTH-1:WIDTH]) begin
              product_q <= '1;
              ovf_q     <= 1'b1;
            end else begin
              product_q <= acc_next[WIDTH-1:0];
              ovf_q     <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= '0;
          grant_q <= '0;
          ptr_q   <= ptr_next;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign grant   = grant_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/pid_mult_scheduler.md
Name: pid_mult_scheduler

Overview:
- Time-multiplexes one iterative shift-and-add multiplier between the three PID gain terms: P (requester 0), I (requester 1) and D (requester 2).
- Replaces one physical multiplier per term with a single shared unit.
- Arbitration is round-robin over a req/done handshake.
- Results are unsigned, saturated to WIDTH bits, and feed the PID output summation.

Parameters:
- WIDTH, 6, operand and product width in bits; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-requester request level; bit i belongs to requester i.
- a0  in  WIDTH  requester 0 multiplicand (error term).
- b0  in  WIDTH  requester 0 multiplier (gain).
- a1  in  WIDTH  requester 1 multiplicand.
- b1  in  WIDTH  requester 1 multiplier.
- a2  in  WIDTH  requester 2 multiplicand.
- b2  in  WIDTH  requester 2 multiplier.
- busy  out  1  high whenever state is not IDLE.
- grant  out  3  one-hot owner of the multiplier; held from the latch edge through the DONE cycle.
- done  out  3  one-hot, one-cycle pulse to the owner when its product is valid.
- product  out  WIDTH  saturated result; holds its value until the next DONE.
- ovf  out  1  high alongside product when saturation occurred; holds with product.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - busy, grant, done, product and ovf all 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Iteration counter and accumulator cleared.
  - rst overrides everything, including mid-operation; an aborted operation produces no done.
- States: IDLE, ITER, DONE.
- IDLE:
  - If req != 0 at edge E0: choose the first asserted requester starting from the pointer and wrapping 0→1→2→0.
  - At E0: set grant, latch that requester's a/b into internal registers, clear accumulator and counter, go to ITER.
  - If req == 0: stay in IDLE.
- ITER:
  - Each edge: if the counter-selected multiplier bit (LSB first) is 1, add (latched a << counter) into a 2*WIDTH accumulator, then increment the counter.
  - Exactly WIDTH iterations at edges E0+1 .. E0+WIDTH, regardless of operand values (fixed latency).
  - At edge E0+WIDTH:
    - Go to DONE.
    - Register product = accumulator upper WIDTH bits nonzero ? all ones : low WIDTH bits.
    - Register ovf accordingly.
    - Assert done[owner].
- DONE:
  - Lasts exactly one cycle, from edge E0+WIDTH to E0+WIDTH+1.
  - At E0+WIDTH+1: done and grant go to 0, the pointer moves to owner+1 mod 3, state goes to IDLE.
- Throughput: next sampling edge is E0+WIDTH+2 at the earliest, so one operation per WIDTH+2 cycles.
- Requester obligations:
  - Hold req until it observes done.
  - Deassert req at the edge it samples done; otherwise it is eligible again under round-robin.
- Operands:
  - Changes on a/b or req after E0 are ignored for the operation in flight.
  - Dropping req mid-operation does not abort it; done and product are still delivered.
- Simultaneous requests: only the pointer order decides, so no requester waits more than two operations.
- Operand edge cases: zero operands give product 0, ovf 0 after the full latency.
- Arithmetic: unsigned; no wrap-around of product; the accumulator cannot overflow 2*WIDTH bits.

Test Plan:
1. After reset, req=001, a0=5, b0=7 (WIDTH=6), sampled at E0 → grant=001 from E0; done=001 for exactly one cycle starting at E0+6; product=35, ovf=0; busy low again after E0+7.
2. req=010, a1=63, b1=63 → product=63, ovf=1; also a1=8, b1=8 → product=63, ovf=1; a1=7, b1=9 → product=63, ovf=0.
3. req=111 held continuously, each requester dropping req for one cycle after its done → service order 0,1,2,0,1 with consecutive grants spaced 8 cycles apart; product matches each requester's operands.
4. req=001 granted, then a0/b0 changed and req dropped at E0+2 → done still pulses at E0+6 with the product of the originally latched operands.
5. rst=1 at E0+3 mid-operation → next cycle busy=0, grant=0, product=0, no done pulse; with req=100 only, a fresh operation starts at the first edge after rst falls.
6. a0=0, b0=63 → product=0, ovf=0, done exactly at E0+6, confirming fixed latency.
